// File: rtl/snitch_data_mem_pkg.sv
// snitch_data_mem_pkg: shared power-state type, SRAM tuning types and helpers for the banked TCDM store.
package snitch_data_mem_pkg;
  typedef enum logic [1:0] {ACTIVE, DRAIN, SLEEP, WAKE} pwr_state_e;
  typedef struct packed {
    logic [1:0] rtsel;
    logic [1:0] wtsel;
  } sram_cfg_t;
  typedef struct packed {
    sram_cfg_t tcdm;
  } sram_cfgs_t;
  function automatic int unsigned bank2grp(int unsigned bank, int unsigned banks_per_group);
    return bank / banks_per_group;
  endfunction
  function automatic logic byte_parity(logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/snitch_data_mem_grp_ctrl.sv
// snitch_data_mem_grp_ctrl: per-group sleep/wake sequencer with in-flight read and wake counters.
module snitch_data_mem_grp_ctrl import snitch_data_mem_pkg::*; #(
  parameter int unsigned CntWidth   = 4,
  parameter int unsigned WakeCycles = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sleep_req_i,
  input  logic [CntWidth-1:0] issue_i,
  input  logic [CntWidth-1:0] retire_i,
  output logic                grp_active_o,
  output logic                sleep_ack_o
);
  localparam int unsigned WakeWidth = $clog2(WakeCycles + 1);
  pwr_state_e state_q, state_d;
  logic [CntWidth-1:0] inflt_q, inflt_d;
  logic [WakeWidth-1:0] wcnt_q, wcnt_d;
  logic active_q, ack_q;
  always_comb begin
    inflt_d = inflt_q + issue_i - retire_i;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ACTIVE: state_d = sleep_req_i ? DRAIN : ACTIVE;
      // Leave DRAIN once the last in-flight read retires this cycle.
      DRAIN:  state_d = !sleep_req_i ? ACTIVE : (inflt_d == '0 ? SLEEP : DRAIN);
      SLEEP: if (!sleep_req_i) begin
        state_d = WAKE;
        wcnt_d  = WakeWidth'(WakeCycles - 1);
      end
      WAKE: if (wcnt_q == '0) state_d = ACTIVE;
            else wcnt_d = wcnt_q - WakeWidth'(1);
      default: state_d = ACTIVE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ACTIVE;
      inflt_q  <= '0;
      wcnt_q   <= '0;
      active_q <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflt_q  <= inflt_d;
      wcnt_q   <= wcnt_d;
      active_q <= state_d == ACTIVE;
      ack_q    <= state_d == SLEEP;
    end
  end
  assign grp_active_o = active_q;
  assign sleep_ack_o  = ack_q;
endmodule

// File: rtl/snitch_data_mem_pwr.sv
// snitch_data_mem_pwr: banked TCDM store with per-group power sequencing and configurable read latency.
// Define SNITCH_DATA_MEM_PARITY_EN to add per-byte even-parity sideband storage and checking.
module snitch_data_mem_pwr import snitch_data_mem_pkg::*; #(
  parameter int unsigned TCDMDepth       = 512,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned NumTotalBanks   = 32,
  parameter int unsigned NumBankGroups   = 4,
  parameter int unsigned ReadLatency     = 1,
  parameter int unsigned WakeCycles      = 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  sram_cfgs_t                                             sram_cfgs_i,
  input  logic [NumTotalBanks-1:0]                               mem_cs_i,
  input  logic [NumTotalBanks-1:0][$clog2(TCDMDepth)-1:0]        mem_add_i,
  input  logic [NumTotalBanks-1:0]                               mem_wen_i,
  input  logic [NumTotalBanks-1:0][NarrowDataWidth/8-1:0]        mem_be_i,
  input  logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]          mem_wdata_i,
  output logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]          mem_rdata_o,
  output logic [NumTotalBanks-1:0]                               mem_rvalid_o,
  output logic [NumTotalBanks-1:0]                               mem_err_o,
  output logic [NumTotalBanks-1:0]                               mem_perr_o,
  input  logic [NumBankGroups-1:0]                               grp_sleep_req_i,
  output logic [NumBankGroups-1:0]                               grp_sleep_ack_o,
  output logic [NumBankGroups-1:0]                               grp_ready_o
);
  localparam int unsigned BanksPerGroup = NumTotalBanks / NumBankGroups;
  localparam int unsigned CntWidth      = $clog2(BanksPerGroup * ReadLatency + 1);
  localparam int unsigned StrbWidth     = NarrowDataWidth / 8;
  typedef logic [$clog2(TCDMDepth)-1:0] tcdm_mem_addr_t;
  typedef logic [StrbWidth-1:0]         strb_t;
  typedef logic [NarrowDataWidth-1:0]   data_t;
  logic [NumBankGroups-1:0] grp_active;
  logic [NumTotalBanks-1:0] acc, rd_acc, err_q, err_d, perr_end;
  logic [ReadLatency-1:0][NumTotalBanks-1:0] rv_q, rv_d;
  data_t [NumTotalBanks-1:0] rdata_end;
  assign rd_acc = acc & ~mem_wen_i;
  always_comb begin
    err_d   = mem_cs_i & ~acc;
    rv_d[0] = rd_acc;
    for (int s = 1; s < ReadLatency; s++) rv_d[s] = rv_q[s-1];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
      rv_q  <= '0;
    end else begin
      err_q <= err_d;
      rv_q  <= rv_d;
    end
  end
  assign mem_rvalid_o = rv_q[ReadLatency-1];
  assign mem_err_o    = err_q;
  assign mem_perr_o   = perr_end & mem_rvalid_o;
  for (genvar g = 0; g < NumBankGroups; g++) begin : gen_grp
    logic [CntWidth-1:0] issue, retire;
    always_comb begin
      issue  = '0;
      retire = '0;
      for (int k = 0; k < BanksPerGroup; k++) begin
        issue  = issue + CntWidth'(rd_acc[g*BanksPerGroup+k]);
        retire = retire + CntWidth'(mem_rvalid_o[g*BanksPerGroup+k]);
      end
    end
    snitch_data_mem_grp_ctrl #(.CntWidth(CntWidth), .WakeCycles(WakeCycles)) i_ctrl (
      .clk_i, .rst_ni,
      .sleep_req_i  (grp_sleep_req_i[g]),
      .issue_i      (issue),
      .retire_i     (retire),
      .grp_active_o (grp_active[g]),
      .sleep_ack_o  (grp_sleep_ack_o[g])
    );
  end
  assign grp_ready_o = grp_active;
  for (genvar b = 0; b < NumTotalBanks; b++) begin : gen_bank
    localparam int unsigned G = bank2grp(b, BanksPerGroup);
    tcdm_mem_addr_t addr;
    data_t mem [TCDMDepth];
    data_t mac_rdata;
    logic mism;
    assign addr   = mem_add_i[b];
    assign acc[b] = mem_cs_i[b] & grp_active[G];
    // Behavioural single-port macro, one cycle read latency, no reset on contents.
    always_ff @(posedge clk_i) begin
      if (acc[b] && !mem_wen_i[b]) mac_rdata <= mem[addr];
      for (int k = 0; k < StrbWidth; k++)
        if (acc[b] && mem_wen_i[b] && mem_be_i[b][k]) mem[addr][8*k+:8] <= mem_wdata_i[b][8*k+:8];
    end
`ifdef SNITCH_DATA_MEM_PARITY_EN
    strb_t par_mem [TCDMDepth];
    strb_t mac_par, pchk;
    always_ff @(posedge clk_i) begin
      if (acc[b] && !mem_wen_i[b]) mac_par <= par_mem[addr];
      for (int k = 0; k < StrbWidth; k++)
        if (acc[b] && mem_wen_i[b] && mem_be_i[b][k]) par_mem[addr][k] <= byte_parity(mem_wdata_i[b][8*k+:8]);
    end
    always_comb begin
      pchk = '0;
      for (int k = 0; k < StrbWidth; k++) pchk[k] = byte_parity(mac_rdata[8*k+:8]) ^ mac_par[k];
    end
    assign mism = |pchk;
`else
    assign mism = 1'b0;
`endif
    if (ReadLatency > 1) begin : gen_dly
      data_t [ReadLatency-2:0] dly_q, dly_d;
      logic [ReadLatency-2:0] pe_q, pe_d;
      always_comb begin
        dly_d[0] = mac_rdata;
        pe_d[0]  = mism;
        for (int s = 1; s < ReadLatency - 1; s++) begin
          dly_d[s] = dly_q[s-1];
          pe_d[s]  = pe_q[s-1];
        end
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dly_q <= '0;
          pe_q  <= '0;
        end else begin
          dly_q <= dly_d;
          pe_q  <= pe_d;
        end
      end
      assign rdata_end[b] = dly_q[ReadLatency-2];
      assign perr_end[b]  = pe_q[ReadLatency-2];
    end else begin : gen_nodly
      assign rdata_end[b] = mac_rdata;
      assign perr_end[b]  = mism;
    end
    assign mem_rdata_o[b] = mem_rvalid_o[b] ? rdata_end[b] : '0;
  end
endmodule

// File: tb/tb_snitch_data_mem_pwr.sv
// tb_snitch_data_mem_pwr: directed checks of data path, partial writes, drain/sleep/wake and async reset.
module tb_snitch_data_mem_pwr;
  import snitch_data_mem_pkg::*;
  localparam logic [63:0] Pat  = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] Part = 64'hFFFF_FFFF_0000_0000;
  logic clk, rst_n;
  sram_cfgs_t cfg;
  logic [31:0] cs, wen, rvalid, err, perr;
  logic [31:0][8:0] add;
  logic [31:0][7:0] be;
  logic [31:0][63:0] wdata, rdata;
  logic [3:0] slp, ack, ready;
  int n_chk, n_pass, n;
  snitch_data_mem_pwr #(.ReadLatency(2), .WakeCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sram_cfgs_i(cfg),
    .mem_cs_i(cs), .mem_add_i(add), .mem_wen_i(wen), .mem_be_i(be), .mem_wdata_i(wdata),
    .mem_rdata_o(rdata), .mem_rvalid_o(rvalid), .mem_err_o(err), .mem_perr_o(perr),
    .grp_sleep_req_i(slp), .grp_sleep_ack_o(ack), .grp_ready_o(ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk); #1;
    cs = '0; wen = '0; be = '0;
  endtask
  task automatic req(input int b, input logic w, input logic [8:0] a, input logic [7:0] m, input logic [63:0] d);
    cs[b] = 1'b1; wen[b] = w; add[b] = a; be[b] = m; wdata[b] = d;
  endtask
  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b1; cfg = '0; cs = '0; wen = '0; add = '0; be = '0; wdata = '0; slp = '0;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 64'(ready), 64'hF);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_rdata", rdata[3], 64'h0);
    rst_n = 1'b1;
    tick();
    req(3, 1'b1, 9'h10, 8'hFF, Pat); tick();
    chk("wr_no_rvalid", 64'(rvalid[3]), 64'h0);
    req(3, 1'b0, 9'h10, 8'h00, 64'h0); tick();
    chk("rd_t1_idle", 64'(rvalid[3]), 64'h0);
    tick();
    chk("rd_t2_valid", 64'(rvalid[3]), 64'h1);
    chk("rd_t2_data", rdata[3], Pat);
    chk("rd_perr", 64'(perr[3]), 64'h0);
    tick();
    chk("rd_pulse", 64'(rvalid[3]), 64'h0);
    chk("rd_zero", rdata[3], 64'h0);
    req(5, 1'b1, 9'h20, 8'hFF, '1); tick();
    req(5, 1'b1, 9'h20, 8'h0F, 64'h0); tick();
    req(5, 1'b0, 9'h20, 8'h00, 64'h0); tick(); tick();
    chk("part_data", rdata[5], Part);
    req(3, 1'b0, 9'h10, 8'h00, 64'h0); req(5, 1'b0, 9'h20, 8'h00, 64'h0); tick();
    slp[0] = 1'b1; req(3, 1'b0, 9'h10, 8'h00, 64'h0); tick();
    chk("drain_ready", 64'(ready[0]), 64'h0);
    chk("drain_rv5", 64'(rvalid[5]), 64'h1);
    chk("drain_d5", rdata[5], Part);
    req(4, 1'b0, 9'h10, 8'h00, 64'h0); tick();
    chk("drain_err4", 64'(err[4]), 64'h1);
    chk("drain_edge_rd", 64'(rvalid[3]), 64'h1);
    chk("drain_edge_d", rdata[3], Pat);
    chk("drain_no_ack", 64'(ack[0]), 64'h0);
    tick();
    chk("sleep_ack", 64'(ack[0]), 64'h1);
    chk("drop_no_rv", 64'(rvalid[4]), 64'h0);
    chk("err_pulse", 64'(err[4]), 64'h0);
    req(3, 1'b1, 9'h10, 8'hFF, 64'h0); req(8, 1'b1, 9'h10, 8'hFF, 64'h1); tick();
    chk("sleep_err3", 64'(err[3]), 64'h1);
    chk("grp1_no_err", 64'(err[8]), 64'h0);
    slp[0] = 1'b0; req(8, 1'b0, 9'h10, 8'h00, 64'h0); tick();
    chk("wake_ack_low", 64'(ack[0]), 64'h0);
    tick();
    chk("grp1_data", rdata[8], 64'h1);
    n = 1;
    while (!ready[0] && n < 20) begin
      tick();
      n++;
    end
    chk("wake_cycles", 64'(n), 64'd8);
    req(3, 1'b0, 9'h10, 8'h00, 64'h0); tick(); tick();
    chk("retained", rdata[3], Pat);
`ifdef SNITCH_DATA_MEM_PARITY_EN
    req(6, 1'b1, 9'h1, 8'hFF, 64'h1234); tick();
    dut.gen_bank[6].mem[1][0] = ~dut.gen_bank[6].mem[1][0];
    req(6, 1'b0, 9'h1, 8'h00, 64'h0); tick(); tick();
    chk("perr_hit", 64'(perr[6]), 64'h1);
    tick();
    chk("perr_pulse", 64'(perr[6]), 64'h0);
`endif
    slp[0] = 1'b1; req(3, 1'b0, 9'h10, 8'h00, 64'h0); req(5, 1'b0, 9'h20, 8'h00, 64'h0); tick();
    chk("pre_rst_drain", 64'(ready[0]), 64'h0);
    rst_n = 1'b0; slp = '0; #1;
    chk("rst_async_ready", 64'(ready), 64'hF);
    chk("rst_async_rv", 64'(rvalid), 64'h0);
    tick();
    chk("rst_hold_rv", 64'(rvalid), 64'h0);
    rst_n = 1'b1; tick();
    chk("post_rst_rv", 64'(rvalid), 64'h0);
    chk("post_rst_ready", 64'(ready), 64'hF);
    chk("post_rst_ack", 64'(ack), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
